// File: rtl/wb_uart_pkg.sv
// Shared constants and state types for the Wishbone UART slave.
package wb_uart_pkg;

    // Register offsets, decoded from adr[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CLKDIV = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // STATUS bit positions
    localparam int ST_TX_BUSY  = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_VALID = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_RX_OVR   = 4;
    localparam int ST_FRM_ERR  = 5;

    // CTRL bit positions
    localparam int CTRL_EN   = 0;
    localparam int CTRL_RXIE = 1;
    localparam int CTRL_TXIE = 2;

    // Shortest usable bit period in clock cycles
    localparam logic [15:0] MIN_DIV = 16'd4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Programmed divider clamped to the minimum bit period
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div < MIN_DIV) ? MIN_DIV : div;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop & (r_count != '0);
    assign w_do_push = i_push & ((r_count != FULL_CNT) | w_do_pop);

    // Storage array; contents need no reset because the count gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + {{PW{1'b0}}, w_do_push} - {{PW{1'b0}}, w_do_pop};
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/wb_uart_slave.sv
// Wishbone UART slave: register file, 8N1 transmitter with a one-byte holding
// buffer, oversampling-free mid-bit receiver feeding an RX FIFO, level interrupt.
module wb_uart_slave
    import wb_uart_pkg::*;
#(
    parameter int          DW       = 32,
    parameter int          AW       = 32,
    parameter int          RX_DEPTH = 4,
    parameter logic [15:0] DEF_DIV  = 16'd868
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wb_stb_i,
    input  logic          wb_cyc_i,
    input  logic          wb_we_i,
    input  logic [3:0]    wb_sel_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          ser_tx,
    input  logic          ser_rx,
    output logic          irq
);
    // Bus and register state
    logic            r_ack;
    logic [DW-1:0]   r_dat_o;
    logic [15:0]     r_clkdiv;
    logic [2:0]      r_ctrl;
    logic            r_rx_ovr;
    logic            r_frm_err;
    logic            r_irq;

    // Transmit state
    logic [7:0]      r_tx_buf;
    logic            r_tx_full;
    tx_state_t       r_tx_state;
    logic [15:0]     r_tx_cnt;
    logic [2:0]      r_tx_bit;
    logic [7:0]      r_tx_shift;
    logic            r_ser_tx;

    // Receive state
    logic            r_rx_s1;
    logic            r_rx_s2;
    logic            r_rx_prev;
    rx_state_t       r_rx_state;
    logic [15:0]     r_rx_cnt;
    logic [2:0]      r_rx_bit;
    logic [7:0]      r_rx_shift;

    logic            w_req;
    logic            w_wr;
    logic            w_rd;
    logic [1:0]      w_reg;
    logic            w_en;
    logic [15:0]     w_div;
    logic            w_pop;
    logic            w_tx_load;
    logic            w_tx_busy;
    logic            w_rx_stop_smp;
    logic            w_rx_push;
    logic            w_rx_ovr_set;
    logic            w_rx_frm_set;
    logic [7:0]      w_rx_data;
    logic            w_rx_full;
    logic            w_rx_empty;
    logic [$clog2(RX_DEPTH):0] w_rx_count;
    logic [DW-1:0]   w_rdata;

    assign w_req     = wb_stb_i & wb_cyc_i & ~r_ack;
    assign w_wr      = w_req & wb_we_i;
    assign w_rd      = w_req & ~wb_we_i;
    assign w_reg     = wb_adr_i[3:2];
    assign w_en      = r_ctrl[CTRL_EN];
    assign w_div     = eff_div(r_clkdiv);
    assign w_pop     = w_rd & (w_reg == REG_DATA) & ~w_rx_empty;
    assign w_tx_load = (r_tx_state == TX_IDLE) & w_en & r_tx_full;
    assign w_tx_busy = (r_tx_state != TX_IDLE);

    // Stop-bit decision: a pop in the same cycle frees a slot, so no overrun then
    assign w_rx_stop_smp = w_en & (r_rx_state == RX_STOP) & (r_rx_cnt == 16'd0);
    assign w_rx_frm_set  = w_rx_stop_smp & ~r_rx_s2;
    assign w_rx_push     = w_rx_stop_smp & r_rx_s2 & (~w_rx_full | w_pop);
    assign w_rx_ovr_set  = w_rx_stop_smp & r_rx_s2 & w_rx_full & ~w_pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .i_push  (w_rx_push),
        .i_pop   (w_pop),
        .i_data  (r_rx_shift),
        .o_data  (w_rx_data),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    // Read-data mux for the addressed register
    always_comb begin
        w_rdata = '0;
        case (w_reg)
            REG_DATA:   w_rdata = w_rx_empty ? '1 : {{(DW-8){1'b0}}, w_rx_data};
            REG_STATUS: w_rdata = {{(DW-6){1'b0}}, r_frm_err, r_rx_ovr, w_rx_full,
                                   (w_rx_count != '0), r_tx_full, w_tx_busy};
            REG_CLKDIV: w_rdata = {{(DW-16){1'b0}}, r_clkdiv};
            REG_CTRL:   w_rdata = {{(DW-3){1'b0}}, r_ctrl};
            default:    w_rdata = '0;
        endcase
    end

    // Single-cycle ack, read data captured with it, byte-lane register writes
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack    <= 1'b0;
            r_dat_o  <= '0;
            r_clkdiv <= DEF_DIV;
            r_ctrl   <= 3'd0;
        end else begin
            r_ack   <= w_req;
            r_dat_o <= w_rd ? w_rdata : '0;
            if (w_wr && (w_reg == REG_CLKDIV)) begin
                if (wb_sel_i[0]) r_clkdiv[7:0]  <= wb_dat_i[7:0];
                if (wb_sel_i[1]) r_clkdiv[15:8] <= wb_dat_i[15:8];
            end
            if (w_wr && (w_reg == REG_CTRL) && wb_sel_i[0]) begin
                r_ctrl <= wb_dat_i[2:0];
            end
        end
    end

    // TX holding buffer and sticky error flags; a new error wins over a clear
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_tx_buf  <= 8'd0;
            r_tx_full <= 1'b0;
            r_rx_ovr  <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            if (w_wr && (w_reg == REG_STATUS) && wb_sel_i[0]) begin
                if (wb_dat_i[ST_RX_OVR])  r_rx_ovr  <= 1'b0;
                if (wb_dat_i[ST_FRM_ERR]) r_frm_err <= 1'b0;
            end
            if (w_rx_ovr_set) r_rx_ovr  <= 1'b1;
            if (w_rx_frm_set) r_frm_err <= 1'b1;
            if (w_tx_load) begin
                r_tx_full <= 1'b0;
            end else if (w_wr && (w_reg == REG_DATA) && wb_sel_i[0] && !r_tx_full) begin
                r_tx_buf  <= wb_dat_i[7:0];
                r_tx_full <= 1'b1;
            end
        end
    end

    // TX FSM; the line lags the state by one cycle so every bit is exactly one period
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= 16'd0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'd0;
            r_ser_tx   <= 1'b1;
        end else if (!w_en) begin
            r_tx_state <= TX_IDLE;
            r_ser_tx   <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_ser_tx <= 1'b1;
                    if (r_tx_full) begin
                        r_tx_shift <= r_tx_buf;
                        r_tx_cnt   <= w_div - 16'd1;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    r_ser_tx <= 1'b0;
                    if (r_tx_cnt == 16'd0) begin
                        r_tx_cnt   <= w_div - 16'd1;
                        r_tx_bit   <= 3'd0;
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt - 16'd1;
                    end
                end
                TX_DATA: begin
                    r_ser_tx <= r_tx_shift[0];
                    if (r_tx_cnt == 16'd0) begin
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_cnt   <= w_div - 16'd1;
                        if (r_tx_bit == 3'd7) begin
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx_bit <= r_tx_bit + 3'd1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt - 16'd1;
                    end
                end
                TX_STOP: begin
                    r_ser_tx <= 1'b1;
                    if (r_tx_cnt == 16'd0) begin
                        r_tx_state <= TX_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt - 16'd1;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous RX pin plus a delayed copy for edge detect
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= ser_rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // RX FSM: half a period to the start-bit centre, then one sample per period
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= 16'd0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'd0;
        end else if (!w_en) begin
            r_rx_state <= RX_IDLE;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_prev && !r_rx_s2) begin
                        r_rx_cnt   <= (w_div >> 1) - 16'd1;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == 16'd0) begin
                        if (r_rx_s2) begin
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_cnt   <= w_div - 16'd1;
                            r_rx_bit   <= 3'd0;
                            r_rx_state <= RX_DATA;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == 16'd0) begin
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        r_rx_cnt   <= w_div - 16'd1;
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 3'd1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == 16'd0) begin
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 16'd1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // Level interrupt, registered
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_ctrl[CTRL_RXIE] & ~w_rx_empty) | (r_ctrl[CTRL_TXIE] & ~r_tx_full);
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat_o;
    assign ser_tx   = r_ser_tx;
    assign irq      = r_irq;

endmodule

// File: tb/tb_wb_uart_slave.sv
// Directed/randomized bench for wb_uart_slave with a line-level serial model.
module tb_wb_uart_slave;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0;
    logic [31:0] dat = 32'h0;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        ser_tx;
    logic        rx_line = 1'b1;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;
    int mon_div = 8;
    logic [8:0] tx_got[$];

    wb_uart_slave dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_stb_i (stb),
        .wb_cyc_i (cyc),
        .wb_we_i  (we),
        .wb_sel_i (sel),
        .wb_adr_i (adr),
        .wb_dat_i (dat),
        .wb_dat_o (dat_o),
        .wb_ack_o (ack_o),
        .ser_tx   (ser_tx),
        .ser_rx   (rx_line),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus transfer, started at a negedge; returns at the negedge of the ack cycle
    task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd);
        logic got;
        got = 1'b0;
        rd  = 32'hDEAD_BEEF;
        stb = 1'b1; cyc = 1'b1; we = w; sel = s;
        adr = 32'h2000_0000 | {28'h0, a, 2'b00};
        dat = d;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (ack_o === 1'b1) begin
                got = 1'b1;
                rd  = dat_o;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        if (!got) check("wb_ack_timeout", {31'h0, got}, 32'h1);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        wb_xfer(1'b1, a, d, s, dummy);
    endtask

    task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        wb_xfer(1'b0, a, 32'h0, 4'hF, rd);
        check(tag, rd, exp);
    endtask

    // Drive one 8N1 frame onto the RX pin, bit period d cycles
    task automatic send_rx(input logic [7:0] b, input int d, input logic stopb);
        rx_line = 1'b0;
        repeat (d) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            rx_line = b[j];
            repeat (d) @(negedge clk);
        end
        rx_line = stopb;
        repeat (d) @(negedge clk);
        rx_line = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Line decoder: samples ser_tx at bit centres and records {stop_error, byte}
    initial begin
        int d;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (ser_tx === 1'b0) begin
                d = mon_div;
                b = 8'h0;
                repeat (d / 2) @(negedge clk);
                for (int j = 0; j < 8; j++) begin
                    repeat (d) @(negedge clk);
                    b[j] = ser_tx;
                end
                repeat (d) @(negedge clk);
                tx_got.push_back({~ser_tx, b});
            end
        end
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  b;
        logic [7:0]  ba;
        logic [7:0]  bb;
        logic [9:0]  frame;
        logic [7:0]  rx_q[$];
        logic        m_ovr;
        int          d;
        int          eff;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ack", {31'h0, ack_o}, 32'h0);
        check("rst_dat", dat_o, 32'h0);
        check("rst_tx", {31'h0, ser_tx}, 32'h1);
        check("rst_irq", {31'h0, irq}, 32'h0);
        rd_check("rst_status", 2'd1, 32'h0);
        @(negedge clk);
        check("ack_one_cycle", {31'h0, ack_o}, 32'h0);
        check("dat_o_idle", dat_o, 32'h0);
        rd_check("rst_clkdiv", 2'd2, 32'd868);
        rd_check("rst_ctrl", 2'd3, 32'h0);

        // Directed 0xA5 frame, cycle exact
        wr_reg(2'd2, 32'd8, 4'hF);
        mon_div = 8;
        wr_reg(2'd3, 32'h1, 4'h1);
        rd_check("clkdiv_rb", 2'd2, 32'd8);
        tx_got.delete();
        wr_reg(2'd0, 32'hA5, 4'h1);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int k = 1; k <= 82; k++) begin
            @(negedge clk);
            if (k == 1 || k == 82) check("tx_idle_edge", {31'h0, ser_tx}, 32'h1);
            else check("tx_bit", {31'h0, ser_tx}, {31'h0, frame[(k - 2) / 8]});
        end
        rd_check("tx_done_status", 2'd1, 32'h0);
        check("tx_dec_cnt", tx_got.size(), 32'd1);
        if (tx_got.size() > 0) check("tx_dec_a5", {23'h0, tx_got[0]}, 32'h0A5);

        // Random bytes, random dividers including values below the minimum
        tx_got.delete();
        for (int it = 0; it < 3; it++) begin
            d   = (it == 0) ? 2 : $urandom_range(4, 12);
            eff = (d < 4) ? 4 : d;
            wr_reg(2'd2, d, 4'hF);
            mon_div = eff;
            b = 8'($urandom);
            wr_reg(2'd0, {24'h0, b}, 4'h1);
            repeat (10 * eff + 10) @(negedge clk);
            check("tx_rand_cnt", tx_got.size(), 32'd1);
            if (tx_got.size() > 0) check("tx_rand_byte", {23'h0, tx_got.pop_front()}, {24'h0, b});
        end

        // Holding buffer: second byte accepted during a frame, third dropped
        wr_reg(2'd2, 32'd8, 4'hF);
        mon_div = 8;
        tx_got.delete();
        ba = 8'($urandom);
        bb = 8'($urandom);
        wr_reg(2'd0, {24'h0, ba}, 4'h1);
        wr_reg(2'd0, {24'h0, bb}, 4'h1);
        wr_reg(2'd0, {24'h0, ~bb}, 4'h1);
        rd_check("tx_busy_full", 2'd1, 32'h3);
        repeat (200) @(negedge clk);
        check("tx_drop_cnt", tx_got.size(), 32'd2);
        if (tx_got.size() == 2) begin
            check("tx_drop_b0", {23'h0, tx_got[0]}, {24'h0, ba});
            check("tx_drop_b1", {23'h0, tx_got[1]}, {24'h0, bb});
        end
        rd_check("tx_drop_status", 2'd1, 32'h0);

        // RX directed 0x3C
        send_rx(8'h3C, 8, 1'b1);
        rd_check("rx_valid", 2'd1, 32'h4);
        rd_check("rx_3c", 2'd0, 32'h3C);
        rd_check("rx_empty_read", 2'd0, 32'hFFFF_FFFF);

        // Overrun: five bytes into a four-entry FIFO
        m_ovr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            send_rx(b, 8, 1'b1);
            if (rx_q.size() < DEPTH) rx_q.push_back(b);
            else m_ovr = 1'b1;
        end
        rd_check("rx_ovr_status", 2'd1,
                 {26'h0, 1'b0, m_ovr, rx_q.size() == DEPTH, rx_q.size() != 0, 2'b00});
        while (rx_q.size() > 0) rd_check("rx_fifo_order", 2'd0, {24'h0, rx_q.pop_front()});
        rd_check("rx_ovr_sticky", 2'd1, 32'h10);
        wr_reg(2'd1, 32'h10, 4'h1);
        rd_check("rx_ovr_clear", 2'd1, 32'h0);

        // Random dividers on receive
        for (int it = 0; it < 3; it++) begin
            d = $urandom_range(8, 16);
            wr_reg(2'd2, d, 4'hF);
            b = 8'($urandom);
            send_rx(b, d, 1'b1);
            rd_check("rx_rand", 2'd0, {24'h0, b});
        end

        // Framing error discards the byte
        wr_reg(2'd2, 32'd8, 4'hF);
        send_rx(8'($urandom), 8, 1'b0);
        rd_check("frm_status", 2'd1, 32'h20);
        rd_check("frm_no_data", 2'd0, 32'hFFFF_FFFF);
        wr_reg(2'd1, 32'h20, 4'h1);
        rd_check("frm_clear", 2'd1, 32'h0);

        // One-cycle glitch
        rx_line = 1'b0;
        @(negedge clk);
        rx_line = 1'b1;
        repeat (40) @(negedge clk);
        rd_check("glitch_status", 2'd1, 32'h0);
        rd_check("glitch_data", 2'd0, 32'hFFFF_FFFF);

        // Disable mid-frame, then buffered byte kept while disabled
        wr_reg(2'd0, 32'h00, 4'h1);
        repeat (20) @(negedge clk);
        check("abort_mid_low", {31'h0, ser_tx}, 32'h0);
        wr_reg(2'd3, 32'h0, 4'h1);
        @(negedge clk);
        check("abort_tx_high", {31'h0, ser_tx}, 32'h1);
        repeat (10) @(negedge clk);
        check("abort_hold_high", {31'h0, ser_tx}, 32'h1);
        repeat (100) @(negedge clk);
        tx_got.delete();
        wr_reg(2'd0, 32'h55, 4'h1);
        rd_check("dis_buf_full", 2'd1, 32'h2);
        repeat (30) @(negedge clk);
        check("dis_no_tx", tx_got.size(), 32'd0);
        wr_reg(2'd3, 32'h1, 4'h1);
        repeat (110) @(negedge clk);
        check("en_tx_cnt", tx_got.size(), 32'd1);
        if (tx_got.size() > 0) check("en_tx_byte", {23'h0, tx_got[0]}, 32'h055);

        // Interrupt sources
        wr_reg(2'd3, 32'h7, 4'h1);
        @(negedge clk);
        check("irq_txie", {31'h0, irq}, 32'h1);
        wr_reg(2'd3, 32'h3, 4'h1);
        @(negedge clk);
        check("irq_rx_empty", {31'h0, irq}, 32'h0);
        send_rx(8'h81, 8, 1'b1);
        check("irq_rxie", {31'h0, irq}, 32'h1);
        rd_check("irq_rx_byte", 2'd0, 32'h81);
        @(negedge clk);
        check("irq_cleared", {31'h0, irq}, 32'h0);

        // Reset in the middle of a frame
        wr_reg(2'd3, 32'h1, 4'h1);
        wr_reg(2'd0, 32'h00, 4'h1);
        repeat (20) @(negedge clk);
        check("rst_mid_low", {31'h0, ser_tx}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", {31'h0, ser_tx}, 32'h1);
        rst = 1'b0;
        rd_check("rst_mid_clkdiv", 2'd2, 32'd868);
        rd_check("rst_mid_ctrl", 2'd3, 32'h0);
        rd_check("rst_mid_status", 2'd1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
